// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_t           op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and response signals of the sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  alu_op_t           cmd_op;

  logic [DATA_W-1:0] alu_a_in;
  logic [DATA_W-1:0] alu_b_in;
  alu_op_t           alu_opcode_in;
  logic [DATA_W-1:0] alu_y_out;
  logic              alu_co_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_co;
  alu_op_t           rsp_op;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_y_out, alu_co_out, rsp_ready,
    output cmd_ready, alu_a_in, alu_b_in, alu_opcode_in, rsp_valid, rsp_y, rsp_co, rsp_op
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_y_out, alu_co_out, rsp_ready,
    input  cmd_ready, alu_a_in, alu_b_in, alu_opcode_in, rsp_valid, rsp_y, rsp_co, rsp_op
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers wrap modulo DEPTH (power of 2).
// A push while full is dropped; the caller gates push with !full.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  alu_cmd_t                     din_i,
  input  logic                         pop_i,
  output alu_cmd_t                     dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  alu_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: queues commands, issues one at a time to the ALU,
// waits ALU_LAT cycles, captures the result and returns it on valid/ready.
// Optional feature macro: ALU_SEQ_STATS_EN adds saturating stat_ops/stat_carries.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  alu_op_sequencer_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]                 stat_ops,
  output logic [15:0]                 stat_carries
`endif
);

  localparam int                CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ALU_LAT - 1);

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, b_q, rsp_y_q;
  alu_op_t            op_q, rsp_op_q;
  logic               rsp_valid_q, rsp_co_q;

  alu_cmd_t           cmd_in, head;
  logic               full, empty, push, pop, capture, xfer;

  assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
  assign push   = bus.cmd_valid && !full;
  assign xfer   = rsp_valid_q && bus.rsp_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (cmd_in),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign bus.cmd_ready     = !full;
  assign bus.alu_a_in      = a_q;
  assign bus.alu_b_in      = b_q;
  assign bus.alu_opcode_in = op_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_y         = rsp_y_q;
  assign bus.rsp_co        = rsp_co_q;
  assign bus.rsp_op        = rsp_op_q;

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, pop/issue and capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (xfer) begin
          if (!empty) begin
            pop     = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers load only on pop; response registers load on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_co_q    <= 1'b0;
      rsp_op_q    <= '0;
    end else begin
      if (pop) begin
        a_q  <= head.a;
        b_q  <= head.b;
        op_q <= head.op;
      end
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_y_q     <= bus.alu_y_out;
        rsp_co_q    <= bus.alu_co_out;
        rsp_op_q    <= op_q;
      end else if (xfer) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_carries_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counters of delivered responses and of those with carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_q     <= '0;
      stat_carries_q <= '0;
    end else if (xfer) begin
      stat_ops_q <= sat_inc(stat_ops_q);
      if (rsp_co_q) stat_carries_q <= sat_inc(stat_carries_q);
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_carries = stat_carries_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder ALU stub.
// Honors ALU_SEQ_STATS_EN when the design is built with it.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_carries;
`endif

  int checks = 0;
  int failures = 0;

  alu_op_sequencer_if bus ();

  logic [8:0] alu_sum;
  assign alu_sum        = {1'b0, bus.alu_a_in} + {1'b0, bus.alu_b_in};
  assign bus.alu_y_out  = alu_sum[7:0];
  assign bus.alu_co_out = alu_sum[8];

  alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .fifo_count   (fifo_count)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_carries (stat_carries)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    if (!bus.rsp_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [7:0] va [5] = '{8'h10, 8'h80, 8'hFF, 8'h01, 8'h7F};
  logic [7:0] vb [5] = '{8'h20, 8'h80, 8'hFF, 8'h02, 8'h01};
  logic [3:0] vo [5] = '{4'h1,  4'h2,  4'h3,  4'h4,  4'h5};
  logic [7:0] ey [5] = '{8'h30, 8'h00, 8'hFE, 8'h03, 8'h80};
  logic       ec [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

  initial begin
    int diffs;
    logic [7:0] sy;
    logic       sc;
    logic [3:0] so;
    logic [7:0] sa;

    // 1. reset with cmd_valid high
    reset         = 1'b1;
    bus.rsp_ready = 1'b0;
    drive_cmd(8'hAA, 8'h55, 4'h7);
    repeat (3) step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_y",     32'(bus.rsp_y), 32'd0);
    chk("rst_rsp_co",    32'(bus.rsp_co), 32'd0);
    chk("rst_rsp_op",    32'(bus.rsp_op), 32'd0);
    chk("rst_alu_a",     32'(bus.alu_a_in), 32'd0);
    chk("rst_alu_b",     32'(bus.alu_b_in), 32'd0);
    chk("rst_alu_op",    32'(bus.alu_opcode_in), 32'd0);
    chk("rst_count",     32'(fifo_count), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("rst_stat_ops",  32'(stat_ops), 32'd0);
`endif
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    step();
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);

    // 2. single command, latency
    bus.rsp_ready = 1'b1;
    drive_cmd(8'h0F, 8'h01, 4'h0);
    step();
    bus.cmd_valid = 1'b0;
    chk("t2_count_t", 32'(fifo_count), 32'd1);
    chk("t2_valid_t", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("t2_alu_a", 32'(bus.alu_a_in), 32'h0F);
    chk("t2_alu_b", 32'(bus.alu_b_in), 32'h01);
    chk("t2_count_t1", 32'(fifo_count), 32'd0);
    chk("t2_valid_t1", 32'(bus.rsp_valid), 32'd0);
    repeat (ALU_LAT) step();
    chk("t2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_y",  32'(bus.rsp_y), 32'h10);
    chk("t2_co", 32'(bus.rsp_co), 32'd0);
    chk("t2_op", 32'(bus.rsp_op), 32'h0);
    step();
    chk("t2_valid_clr", 32'(bus.rsp_valid), 32'd0);

    // 3. carry case
    drive_cmd(8'hFF, 8'h02, 4'h3);
    step();
    bus.cmd_valid = 1'b0;
    wait_rsp("t3");
    chk("t3_y",  32'(bus.rsp_y), 32'h01);
    chk("t3_co", 32'(bus.rsp_co), 32'd1);
    chk("t3_op", 32'(bus.rsp_op), 32'h3);
    step();
`ifdef ALU_SEQ_STATS_EN
    chk("t3_stat_carries", 32'(stat_carries), 32'd1);
    chk("t3_stat_ops",     32'(stat_ops), 32'd2);
`endif

    // 4. fill: 1 in flight + DEPTH queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_ready_%0d", i), 32'(bus.cmd_ready), 32'd1);
      drive_cmd(va[i], vb[i], vo[i]);
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("t4_ready_full", 32'(bus.cmd_ready), 32'd0);
    chk("t4_count_full", 32'(fifo_count), 32'd4);

    // 5. backpressure, then in-order drain
    chk("t5_valid0", 32'(bus.rsp_valid), 32'd1);
    chk("t5_y0",  32'(bus.rsp_y), 32'(ey[0]));
    chk("t5_co0", 32'(bus.rsp_co), 32'(ec[0]));
    chk("t5_op0", 32'(bus.rsp_op), 32'(vo[0]));
    sy = bus.rsp_y; sc = bus.rsp_co; so = bus.rsp_op; sa = bus.alu_a_in;
    diffs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== sy || bus.rsp_co !== sc ||
          bus.rsp_op !== so || bus.alu_a_in !== sa || fifo_count !== 3'd4) diffs++;
    end
    chk("t5_hold_stable", 32'(diffs), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    chk("t5_issue_a",     32'(bus.alu_a_in), 32'(va[1]));
    chk("t5_issue_op",    32'(bus.alu_opcode_in), 32'(vo[1]));
    chk("t5_issue_count", 32'(fifo_count), 32'd3);
    chk("t5_issue_valid", 32'(bus.rsp_valid), 32'd0);
    for (int k = 1; k < 5; k++) begin
      wait_rsp($sformatf("t5_%0d", k));
      chk($sformatf("t5_y_%0d", k),  32'(bus.rsp_y), 32'(ey[k]));
      chk($sformatf("t5_co_%0d", k), 32'(bus.rsp_co), 32'(ec[k]));
      chk($sformatf("t5_op_%0d", k), 32'(bus.rsp_op), 32'(vo[k]));
      step();
    end
    chk("t5_drained", 32'(fifo_count), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("t5_stat_ops",     32'(stat_ops), 32'd7);
    chk("t5_stat_carries", 32'(stat_carries), 32'd3);
`endif

    // 6. reset during WAIT with 2 queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(va[i], vb[i], vo[i]);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    chk("t6_pre_count", 32'(fifo_count), 32'd2);
    chk("t6_pre_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_count", 32'(fifo_count), 32'd0);
    diffs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rsp_valid !== 1'b0) diffs++;
    end
    chk("t6_no_rsp", 32'(diffs), 32'd0);
    drive_cmd(8'h21, 8'h22, 4'h6);
    step();
    bus.cmd_valid = 1'b0;
    wait_rsp("t6");
    chk("t6_y",  32'(bus.rsp_y), 32'h43);
    chk("t6_co", 32'(bus.rsp_co), 32'd0);
    chk("t6_op", 32'(bus.rsp_op), 32'h6);
    step();
`ifdef ALU_SEQ_STATS_EN
    chk("t6_stat_ops", 32'(stat_ops), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
